alu_misr_checker: RTL and testbench
===================================

Name: alu_misr_checker

Overview:
- Response-side companion to the ALU stimulus path: consumes the 16-bit ALU result stream and compacts it into a 16-bit MISR signature.
- Compares the signature against an expected value and reports pass/fail.
- Used in self-checking benches and in BIST wrappers around the 16-bit ALU units (xor_gate, and_gate, adder, ...).
- Sample count is programmed per run; the result is held until acknowledged.

Parameters:
- WIDTH, 16, data and signature width.
- CNT_W, 8, width of sample_count; maximum run length is 2^CNT_W-1.
- POLY, 16'h100B, feedback taps for x^16+x^12+x^3+x+1. Bit 16 is implicit.
- SEED, 16'h0000, signature value loaded at start.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a run; sampled only in IDLE.
- sample_count  input  CNT_W  number of samples to compact; latched on start.
- expected  input  WIDTH  golden signature; latched on start.
- in_valid  input  1  in_data is valid this cycle.
- in_data  input  WIDTH  ALU result word.
- in_ready  output  1  high in RUN. A sample is accepted when in_valid && in_ready.
- busy  output  1  high in RUN or DONE.
- done  output  1  high in DONE.
- pass  output  1  signature == latched expected; valid while done.
- signature  output  WIDTH  current signature register.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - in_ready, busy, done and pass are 0.
  - signature=0, remaining=0, expected latch=0.
  - Reset mid-run aborts immediately with no partial result.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - On start: signature<=SEED, exp_q<=expected, remaining<=sample_count.
  - Next state is RUN if sample_count != 0; otherwise DONE, reporting SEED.
- RUN, on each accepted sample:
  - signature <= {signature[WIDTH-2:0],1'b0} ^ (signature[WIDTH-1] ? POLY : 0) ^ in_data.
  - remaining decrements.
  - Accepting with remaining==1 moves to DONE.
  - in_valid=0 cycles leave all state unchanged. Gaps of any length are allowed.
- DONE:
  - done=1, and pass is a registered compare of signature against exp_q, updated on entry to DONE.
  - signature and pass hold.
  - in_ready=0; input samples are ignored.
  - ack is the start pulse: start in DONE returns to IDLE with done=0. The same-cycle start is not treated as a new run; a new run needs a start in IDLE.
- start in RUN is ignored; sample_count and expected changes are ignored after latching.
- Latency: done rises on the clock edge that accepts the last sample (visible the following cycle). With sample_count=0, done rises on the edge after start.
- Remaining counter never wraps: decrement only in RUN with remaining>=1.
- All arithmetic is GF(2): no carries, no sign handling. Signature width is exactly WIDTH.

Decomposition:
- Shared package alu_pkg:
  - ALU_WIDTH=16.
  - MISR_POLY_16=16'h100B.
  - FSM state enum {ST_IDLE, ST_RUN, ST_DONE}.
- One natural sub-module: misr_step, combinational next-signature function (sig, data -> next). It is reused by the stimulus-side LFSR generator and the bench reference model.

Test Plan:
- Basic accumulate: SEED=0, count=1, expected=16'h0001, sample 16'h0001 -> next cycle done=1, signature=16'h0001, pass=1.
- Feedback path: count=2, samples 16'h8000 then 16'h0000, expected=16'h100B -> done=1, signature=16'h100B, pass=1. Expected=16'h100A gives pass=0.
- Gaps: count=2 with in_valid low for 3 cycles between samples -> same result as the feedback-path case. in_ready stays 1 throughout RUN, and done is not asserted early.
- Zero count: start with count=0, expected=16'h0000 -> done=1 on the next cycle, signature=16'h0000, pass=1. No samples are accepted.
- Ignored start and ack: start pulses during RUN have no effect on the count of 3 samples. In DONE, drive 5 extra valid samples -> signature unchanged. A start pulse -> done=0, back in IDLE.
- Reset mid-run: rst_n low after 1 of 4 samples -> outputs clear asynchronously (signature=0, busy=0). A fresh run after release matches the reference model.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the 16-bit ALU stimulus/response path.
package alu_pkg;

    localparam int ALU_WIDTH = 16;

    // x^16 + x^12 + x^3 + x + 1; the x^16 term is implicit.
    localparam logic [ALU_WIDTH-1:0] MISR_POLY_16 = 16'h100B;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } misr_state_e;

endpackage : alu_pkg

// File: rtl/alu_misr_checker_if.sv
// Run-control and sample bus of the MISR response checker.
interface alu_misr_checker_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
);
    logic             start;
    logic [CNT_W-1:0] sample_count;
    logic [WIDTH-1:0] expected;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             busy;
    logic             done;
    logic             pass;
    logic [WIDTH-1:0] signature;

    // Stimulus/control side: starts runs and feeds ALU results.
    modport master (
        output start, sample_count, expected, in_valid, in_data,
        input  in_ready, busy, done, pass, signature
    );

    // Checker side.
    modport slave (
        input  start, sample_count, expected, in_valid, in_data,
        output in_ready, busy, done, pass, signature
    );
endinterface : alu_misr_checker_if

// File: rtl/alu_misr_checker_misr_step.sv
// One MISR compaction step: shift left, fold the dropped MSB back through
// the feedback taps, then XOR in the new data word. Pure GF(2), no carries.
module misr_step
    import alu_pkg::*;
#(
    parameter int               WIDTH = ALU_WIDTH,
    parameter logic [WIDTH-1:0] POLY  = MISR_POLY_16
) (
    input  logic [WIDTH-1:0] sig_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] next_o
);

    // Galois-style shift with feedback selected by the outgoing MSB.
    always_comb begin
        next_o = {sig_i[WIDTH-2:0], 1'b0}
               ^ (sig_i[WIDTH-1] ? POLY : '0)
               ^ data_i;
    end

endmodule : misr_step

// File: rtl/alu_misr_checker.sv
// MISR response checker: compacts a programmed number of ALU result words
// into a signature, compares against a latched golden value, and holds the
// verdict until a start pulse acknowledges it.
module alu_misr_checker
    import alu_pkg::*;
#(
    parameter int               WIDTH = ALU_WIDTH,
    parameter int               CNT_W = 8,
    parameter logic [WIDTH-1:0] POLY  = MISR_POLY_16,
    parameter logic [WIDTH-1:0] SEED  = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_misr_checker_if.slave    bus
);

    misr_state_e      state_q, state_d;
    logic [WIDTH-1:0] sig_q,   sig_d;
    logic [WIDTH-1:0] exp_q,   exp_d;
    logic [CNT_W-1:0] rem_q,   rem_d;
    logic             pass_q,  pass_d;

    logic [WIDTH-1:0] sig_next;
    logic             accept;

    misr_step #(
        .WIDTH (WIDTH),
        .POLY  (POLY)
    ) u_step (
        .sig_i  (sig_q),
        .data_i (bus.in_data),
        .next_o (sig_next)
    );

    // A sample only counts in RUN; remaining==0 is guarded so it never wraps.
    assign accept = (state_q == ST_RUN) && bus.in_valid && (rem_q != '0);

    // State register; reset mid-run discards everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sig_q   <= '0;
            exp_q   <= '0;
            rem_q   <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sig_q   <= sig_d;
            exp_q   <= exp_d;
            rem_q   <= rem_d;
            pass_q  <= pass_d;
        end
    end

    // Next-state logic; the verdict is computed from the value entering DONE.
    always_comb begin
        state_d = state_q;
        sig_d   = sig_q;
        exp_d   = exp_q;
        rem_d   = rem_q;
        pass_d  = pass_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    sig_d = SEED;
                    exp_d = bus.expected;
                    rem_d = bus.sample_count;
                    if (bus.sample_count == '0) begin
                        state_d = ST_DONE;
                        pass_d  = (SEED == bus.expected);
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (accept) begin
                    sig_d = sig_next;
                    rem_d = rem_q - 1'b1;
                    if (rem_q == CNT_W'(1)) begin
                        state_d = ST_DONE;
                        pass_d  = (sig_next == exp_q);
                    end
                end
            end
            ST_DONE: begin
                // The start here is only an acknowledge, not a new run.
                if (bus.start) begin
                    state_d = ST_IDLE;
                    pass_d  = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Status outputs decode directly from the state register.
    always_comb begin
        bus.in_ready  = (state_q == ST_RUN);
        bus.busy      = (state_q != ST_IDLE);
        bus.done      = (state_q == ST_DONE);
        bus.pass      = pass_q;
        bus.signature = sig_q;
    end

endmodule : alu_misr_checker

// File: tb/tb_alu_misr_checker.sv
// Directed-vector bench for alu_misr_checker with hand-computed signatures.
module tb_alu_misr_checker;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    alu_misr_checker_if #(.WIDTH(16), .CNT_W(8)) bus ();

    alu_misr_checker dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input logic [7:0] cnt, input logic [15:0] exp);
        bus.start        = 1'b1;
        bus.sample_count = cnt;
        bus.expected     = exp;
        tick();
        bus.start        = 1'b0;
    endtask

    task automatic send(input logic [15:0] d);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        tick();
        bus.in_valid = 1'b0;
        bus.in_data  = 16'h0000;
    endtask

    task automatic ack(input string tag);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk({tag, "_ack_done"}, 32'(bus.done), 32'd0);
        chk({tag, "_ack_busy"}, 32'(bus.busy), 32'd0);
        tick();
        chk({tag, "_idle_busy"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.start        = 1'b0;
        bus.sample_count = 8'd0;
        bus.expected     = 16'h0000;
        bus.in_valid     = 1'b0;
        bus.in_data      = 16'h0000;

        // Reset state
        #12;
        chk("rst_sig",   32'(bus.signature), 32'h0);
        chk("rst_busy",  32'(bus.busy),      32'd0);
        chk("rst_done",  32'(bus.done),      32'd0);
        chk("rst_ready", 32'(bus.in_ready),  32'd0);
        chk("rst_pass",  32'(bus.pass),      32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Basic accumulate: 0 -> 0x0001
        start_run(8'd1, 16'h0001);
        chk("b_ready", 32'(bus.in_ready), 32'd1);
        chk("b_busy",  32'(bus.busy),     32'd1);
        chk("b_done0", 32'(bus.done),     32'd0);
        send(16'h0001);
        chk("b_done",  32'(bus.done),      32'd1);
        chk("b_sig",   32'(bus.signature), 32'h0001);
        chk("b_pass",  32'(bus.pass),      32'd1);
        chk("b_rdy0",  32'(bus.in_ready),  32'd0);
        ack("b");

        // Feedback: 0x8000 then 0x0000 -> 0x100B
        start_run(8'd2, 16'h100B);
        send(16'h8000);
        chk("f_mid_done", 32'(bus.done),      32'd0);
        chk("f_mid_sig",  32'(bus.signature), 32'h8000);
        send(16'h0000);
        chk("f_done", 32'(bus.done),      32'd1);
        chk("f_sig",  32'(bus.signature), 32'h100B);
        chk("f_pass", 32'(bus.pass),      32'd1);
        ack("f");

        // Same data, wrong golden value
        start_run(8'd2, 16'h100A);
        send(16'h8000);
        send(16'h0000);
        chk("fw_done", 32'(bus.done),      32'd1);
        chk("fw_sig",  32'(bus.signature), 32'h100B);
        chk("fw_pass", 32'(bus.pass),      32'd0);
        ack("fw");

        // Gaps between samples
        start_run(8'd2, 16'h100B);
        send(16'h8000);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("g_ready", 32'(bus.in_ready),  32'd1);
            chk("g_done",  32'(bus.done),      32'd0);
            chk("g_sig",   32'(bus.signature), 32'h8000);
        end
        send(16'h0000);
        chk("g_fdone", 32'(bus.done),      32'd1);
        chk("g_fsig",  32'(bus.signature), 32'h100B);
        chk("g_fpass", 32'(bus.pass),      32'd1);
        ack("g");

        // Zero count reports SEED on the next cycle
        start_run(8'd0, 16'h0000);
        chk("z_done",  32'(bus.done),      32'd1);
        chk("z_sig",   32'(bus.signature), 32'h0000);
        chk("z_pass",  32'(bus.pass),      32'd1);
        chk("z_ready", 32'(bus.in_ready),  32'd0);
        send(16'hFFFF);
        chk("z_hold",  32'(bus.signature), 32'h0000);
        ack("z");

        // Starts and input changes during RUN are ignored; 1,2,4 -> 0x0004
        start_run(8'd3, 16'h0004);
        bus.start        = 1'b1;
        bus.sample_count = 8'd1;
        bus.expected     = 16'hFFFF;
        tick();
        bus.start = 1'b0;
        chk("i_busy",  32'(bus.busy),     32'd1);
        chk("i_ready", 32'(bus.in_ready), 32'd1);
        send(16'h0001);
        chk("i_s1", 32'(bus.signature), 32'h0001);
        bus.start = 1'b1;
        send(16'h0002);
        bus.start = 1'b0;
        chk("i_s2",    32'(bus.signature), 32'h0000);
        chk("i_done2", 32'(bus.done),      32'd0);
        send(16'h0004);
        chk("i_done", 32'(bus.done),      32'd1);
        chk("i_sig",  32'(bus.signature), 32'h0004);
        chk("i_pass", 32'(bus.pass),      32'd1);
        for (int i = 0; i < 5; i++) send(16'hA5A5);
        chk("i_hold_sig",  32'(bus.signature), 32'h0004);
        chk("i_hold_done", 32'(bus.done),      32'd1);
        chk("i_hold_pass", 32'(bus.pass),      32'd1);
        ack("i");

        // Reset mid-run clears asynchronously
        start_run(8'd4, 16'h0000);
        send(16'h1234);
        chk("r_sig1", 32'(bus.signature), 32'h1234);
        #2;
        rst_n = 1'b0;
        #1;
        chk("r_sig",   32'(bus.signature), 32'h0);
        chk("r_busy",  32'(bus.busy),      32'd0);
        chk("r_done",  32'(bus.done),      32'd0);
        chk("r_ready", 32'(bus.in_ready),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        // Fresh run: 0x8001, 0x0003 -> 0x1009 ^ 0x0003 = 0x100A
        start_run(8'd2, 16'h100A);
        send(16'h8001);
        chk("r2_s1", 32'(bus.signature), 32'h8001);
        send(16'h0003);
        chk("r2_done", 32'(bus.done),      32'd1);
        chk("r2_sig",  32'(bus.signature), 32'h100A);
        chk("r2_pass", 32'(bus.pass),      32'd1);
        ack("r2");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_alu_misr_checker
